// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 9-bit memory/IO bus among NREQ requesters.
// Each transfer runs over two cycles: the bus is driven, then the access is acked.
module bus_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 9,
  parameter int unsigned DW   = 9
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ-1:0]   we,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_dout,
  output logic              bus_write,
  input  logic [DW-1:0]     bus_din,
  output logic              busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_dout_q, bus_dout_d;
  logic            bus_write_q, bus_write_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] owner_q, owner_d;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*AW +: AW];
    assign wdata_arr[g] = wdata[g*DW +: DW];
  end

  logic [NREQ-1:0] cand;
  logic            win_valid;
  logic [IdxW-1:0] win_idx;

  always_comb begin
    cand = req;
    // The owner being acked cannot win again straight away.
    if (state_q == StRespond) begin
      cand = req & ~(NREQ'(1) << owner_q);
    end
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!win_valid && cand[IdxW'((32'(last_q) + i) % NREQ)]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'((32'(last_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    bus_write_d = 1'b0;
    last_d      = last_q;
    owner_d     = owner_q;
    unique case (state_q)
      StIdle, StRespond: begin
        state_d = StIdle;
        gnt_d   = '0;
        if (win_valid) begin
          state_d     = StAccess;
          owner_d     = win_idx;
          gnt_d       = NREQ'(1) << win_idx;
          bus_addr_d  = addr_arr[win_idx];
          bus_dout_d  = wdata_arr[win_idx];
          bus_write_d = we[win_idx];
        end
      end
      StAccess: begin
        state_d = StRespond;
        ack_d   = gnt_q;
        last_d  = owner_q;
        if (!bus_write_q) begin
          rdata_d = bus_din;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
      bus_write_q <= 1'b0;
      last_q      <= IdxW'(NREQ - 1);
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      bus_write_q <= bus_write_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_dout  = bus_dout_q;
  assign bus_write = bus_write_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vectors, multi-cycle sequences and a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 9;
  localparam int DW = 9;

  logic              clock = 1'b0;
  logic              resetn;
  logic [N-1:0]      req, we, gnt, ack;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [DW-1:0]     rdata, bus_dout, bus_din;
  logic [AW-1:0]     bus_addr;
  logic              bus_write, busy;

  int n_checks = 0;
  int n_err    = 0;

  bus_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_write (bus_write),
    .bus_din   (bus_din),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] init_val(input int i);
    return (i == 5) ? 9'h1A3 : 9'(i * 37 + 11);
  endfunction

  // Downstream devices: flat memory, region 2'b11 unmapped (reads 0, writes ignored).
  logic [DW-1:0] dev_mem [512];
  assign bus_din = (bus_addr[8:7] == 2'b11) ? '0 : dev_mem[bus_addr];
  always @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 512; i++) dev_mem[i] <= init_val(i);
    end else if (bus_write && bus_addr[8:7] != 2'b11) begin
      dev_mem[bus_addr] <= bus_dout;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [8:0] a, input logic [8:0] d);
    req[i]             = 1'b1;
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  typedef struct {
    int         who;
    bit         w;
    logic [8:0] a;
    logic [8:0] d;
    logic [8:0] exp_rd;
  } vec_t;

  typedef struct {
    bit         pend;
    bit         granted;
    bit         w;
    logic [8:0] a;
    logic [8:0] d;
    int         skips;
    int         wr_seen;
  } txn_t;

  // Reference model state for the randomized run.
  txn_t          t [N];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] exp_rdata;
  logic [N-1:0]  req_edge, prev_gnt, exp_ack;
  bit            prev_busy;
  int            cyc, ack_due, owner;

  function automatic logic [8:0] ref_rd(input logic [8:0] a);
    return (a[8:7] == 2'b11) ? 9'h000 : ref_mem[a];
  endfunction

  function automatic int gnt_index(input logic [N-1:0] g);
    int r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic new_txn(input int i);
    logic [8:0] a;
    a = 9'($urandom_range(0, 511)) & 9'h18F;
    t[i].pend    = 1'b1;
    t[i].granted = 1'b0;
    t[i].w       = 1'($urandom_range(0, 1));
    t[i].a       = a;
    t[i].d       = 9'($urandom_range(0, 511));
    t[i].skips   = 0;
    t[i].wr_seen = 0;
    set_req(i, t[i].w, t[i].a, t[i].d);
  endtask

  vec_t         vecs [8];
  logic [N-1:0] exp_g [9];
  logic [N-1:0] exp_a [9];
  int           nack [N];

  initial begin
    vecs[0] = '{0, 1'b0, 9'h005, 9'h000, 9'h1A3};
    vecs[1] = '{1, 1'b1, 9'h100, 9'h0FF, 9'h1A3};
    vecs[2] = '{0, 1'b0, 9'h100, 9'h000, 9'h0FF};
    vecs[3] = '{1, 1'b1, 9'h1C0, 9'h155, 9'h0FF};
    vecs[4] = '{0, 1'b0, 9'h1C0, 9'h000, 9'h000};
    vecs[5] = '{1, 1'b1, 9'h010, 9'h0AA, 9'h000};
    vecs[6] = '{1, 1'b0, 9'h010, 9'h000, 9'h0AA};
    vecs[7] = '{0, 1'b0, 9'h005, 9'h000, 9'h1A3};

    resetn = 1'b0;
    req    = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;
    repeat (3) tick();
    check("reset_gnt", gnt, 0);
    check("reset_ack", ack, 0);
    check("reset_rdata", rdata, 0);
    check("reset_bus_addr", bus_addr, 0);
    check("reset_bus_dout", bus_dout, 0);
    check("reset_bus_write", bus_write, 0);
    check("reset_busy", busy, 0);
    resetn = 1'b1;
    tick();

    // Single transfers, one at a time.
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].who, vecs[v].w, vecs[v].a, vecs[v].d);
      tick();
      check($sformatf("vec%0d_gnt", v), gnt, 32'(1) << vecs[v].who);
      check($sformatf("vec%0d_bus_addr", v), bus_addr, vecs[v].a);
      check($sformatf("vec%0d_bus_write", v), bus_write, vecs[v].w);
      if (vecs[v].w) check($sformatf("vec%0d_bus_dout", v), bus_dout, vecs[v].d);
      check($sformatf("vec%0d_ack_early", v), ack, 0);
      tick();
      check($sformatf("vec%0d_ack", v), ack, 32'(1) << vecs[v].who);
      check($sformatf("vec%0d_gnt_hold", v), gnt, 32'(1) << vecs[v].who);
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rd);
      check($sformatf("vec%0d_write_off", v), bus_write, 0);
      req[vecs[v].who] = 1'b0;
      tick();
      check($sformatf("vec%0d_idle_gnt", v), gnt, 0);
      check($sformatf("vec%0d_idle_ack", v), ack, 0);
      check($sformatf("vec%0d_idle_busy", v), busy, 0);
    end

    // Reset during a write in ACCESS; requester 0 last won, but 0 must win again.
    set_req(0, 1'b1, 9'h020, 9'h011);
    tick();
    check("rst_pre_write", bus_write, 1);
    #2 resetn = 1'b0;
    #1;
    check("rst_async_write", bus_write, 0);
    check("rst_async_gnt", gnt, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_rdata", rdata, 0);
    check("rst_async_bus_addr", bus_addr, 0);
    tick();
    check("rst_no_ack", ack, 0);
    resetn = 1'b1;
    set_req(1, 1'b0, 9'h005, 9'h000);
    tick();
    check("rst_first_gnt", gnt, 2'b01);
    tick();
    check("rst_first_ack", ack, 2'b01);
    req[0] = 1'b0;
    tick();
    check("rst_second_gnt", gnt, 2'b10);
    tick();
    check("rst_second_ack", ack, 2'b10);
    req[1] = 1'b0;
    tick();
    check("rst_end_gnt", gnt, 0);

    // Contention: both want two transfers, back-to-back alternation.
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    exp_a = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    nack  = '{0, 0};
    set_req(0, 1'b0, 9'h005, 9'h000);
    set_req(1, 1'b0, 9'h010, 9'h000);
    for (int c = 0; c < 9; c++) begin
      tick();
      check($sformatf("cont%0d_gnt", c), gnt, exp_g[c]);
      check($sformatf("cont%0d_ack", c), ack, exp_a[c]);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          nack[i]++;
          if (nack[i] == 2) req[i] = 1'b0;
        end
      end
    end

    // Withdrawal: requester 1 drops before it can be granted.
    set_req(0, 1'b0, 9'h005, 9'h000);
    tick();
    check("wd_gnt0", gnt, 2'b01);
    set_req(1, 1'b0, 9'h010, 9'h000);
    tick();
    check("wd_ack0", ack, 2'b01);
    req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("wd%0d_gnt", c), gnt, 0);
      check($sformatf("wd%0d_busy", c), busy, 0);
      check($sformatf("wd%0d_write", c), bus_write, 0);
    end

    // Same owner keeps req high: one IDLE cycle, acks three cycles apart.
    exp_g[0:4] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
    exp_a[0:4] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    set_req(0, 1'b0, 9'h005, 9'h000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("rep%0d_gnt", c), gnt, exp_g[c]);
      check($sformatf("rep%0d_ack", c), ack, exp_a[c]);
    end
    req[0] = 1'b0;
    tick();
    check("rep_end_gnt", gnt, 0);

    // Randomized run against the transaction-level model.
    resetn = 1'b0;
    req    = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < N; i++) begin
      t[i].pend    = 1'b0;
      t[i].granted = 1'b0;
    end
    tick();
    tick();
    resetn    = 1'b1;
    exp_rdata = '0;
    ack_due   = -1;
    owner     = 0;
    cyc       = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!t[i].pend) begin
          if ($urandom_range(0, 2) == 0) new_txn(i);
        end else if (!t[i].granted && $urandom_range(0, 7) == 0) begin
          t[i].pend = 1'b0;
          req[i]    = 1'b0;
        end else if (t[i].granted && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b0;
        end
      end
      req_edge  = req;
      prev_busy = busy;
      prev_gnt  = gnt;
      tick();
      cyc++;

      check("rnd_gnt_onehot", 32'($onehot0(gnt)), 1);
      check("rnd_ack_in_gnt", ack & ~gnt, 0);
      check("rnd_write_busy", bus_write & ~busy, 0);
      check("rnd_busy", busy, gnt != 0);
      if (!prev_busy) check("rnd_idle_grant", gnt != 0, req_edge != 0);

      if (gnt != 0 && gnt != prev_gnt) begin
        owner   = gnt_index(gnt);
        ack_due = cyc + 1;
        check("rnd_grant_req", req_edge[owner], 1);
        check("rnd_grant_pend", t[owner].pend, 1);
        check("rnd_grant_addr", bus_addr, t[owner].a);
        check("rnd_grant_we", bus_write, t[owner].w);
        if (t[owner].w) check("rnd_grant_dout", bus_dout, t[owner].d);
        t[owner].granted = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (j != owner && t[j].pend && req_edge[j]) begin
            t[j].skips++;
            check("rnd_fair_wait", t[j].skips <= N - 1, 1);
          end
        end
      end

      exp_ack = (cyc == ack_due) ? (N'(1) << owner) : '0;
      check("rnd_ack_timing", ack, exp_ack);
      if (bus_write) t[gnt_index(gnt)].wr_seen++;

      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          check("rnd_ack_pend", t[i].pend, 1);
          if (t[i].w) begin
            check("rnd_write_once", t[i].wr_seen, 1);
            check("rnd_rdata_held", rdata, exp_rdata);
            if (t[i].a[8:7] != 2'b11) ref_mem[t[i].a] = t[i].d;
          end else begin
            exp_rdata = ref_rd(t[i].a);
            check("rnd_rdata", rdata, exp_rdata);
          end
          t[i].pend    = 1'b0;
          t[i].granted = 1'b0;
          req[i]       = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
